// File: rtl/meas_demux_pkg.sv
// Shared definitions for the measurement demux.
//   state_e  : frame FSM encoding (IDLE / FILL / HOLD)
//   clog2    : constant ceil(log2) helper for sizing indices
//   idx_fits : elaboration-time check that an index width covers a slot count
package meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic bit idx_fits(input int unsigned n, input int unsigned w);
    return (64'(1) << w) >= 64'(n);
  endfunction

endpackage

// File: rtl/meas_demux_if.sv
// Word-source handshake between the measurement datapath and meas_demux.
//   I_valid : source has a word
//   I_data  : measurement word
//   O_ready : demux accepts a word this cycle
// master = word source, slave = meas_demux.
interface meas_demux_if #(
  parameter int unsigned C_IDWIDTH = 24
);
  logic                 I_valid;
  logic [C_IDWIDTH-1:0] I_data;
  logic                 O_ready;

  modport master (output I_valid, output I_data, input  O_ready);
  modport slave  (input  I_valid, input  I_data, output O_ready);
endinterface

// File: rtl/meas_demux.sv
// Gathers a serial stream of C_IDWIDTH-bit words into C_INUM slots and
// presents them as a flat bus (slot k at [k*C_IDWIDTH +: C_IDWIDTH]).
// Ports:
//   I_clk, I_rst_n : clock, synchronous active-low reset
//   I_start        : begin (or restart) a frame
//   src            : word source handshake (valid/data in, ready out)
//   I_ack          : consumer has read the completed frame
//   O_data         : registered slot bank
//   O_idx          : next slot to be written
//   O_busy         : frame being filled
//   O_done         : frame complete, O_data stable
//   O_ovf          : one-cycle pulse per dropped word
module meas_demux
  import meas_pkg::*;
#(
  parameter int unsigned C_INUM    = 48,
  parameter int unsigned C_IDWIDTH = 24,
  parameter int unsigned C_ISWIDTH = 10
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_start,
  meas_demux_if.slave                   src,
  input  logic                          I_ack,
  output logic [C_INUM*C_IDWIDTH-1:0]   O_data,
  output logic [C_ISWIDTH-1:0]          O_idx,
  output logic                          O_busy,
  output logic                          O_done,
  output logic                          O_ovf
);

  if (!idx_fits(C_INUM, C_ISWIDTH)) begin : g_bad_iswidth
    $error("meas_demux: C_ISWIDTH too small for C_INUM");
  end

  state_e               r_state;
  state_e               w_state_nxt;
  logic [C_ISWIDTH-1:0] r_idx;
  logic [C_ISWIDTH-1:0] w_idx_nxt;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 w_clear;
  logic                 w_accept;
  logic [C_IDWIDTH-1:0] r_slot [C_INUM];

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Start outranks accept in FILL; any offered word not accepted is an overflow.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (I_start) begin
          w_state_nxt = ST_FILL;
          w_idx_nxt   = '0;
          w_clear     = 1'b1;
        end
      end
      ST_FILL: begin
        if (I_start) begin
          w_idx_nxt = '0;
          w_clear   = 1'b1;
        end else if (src.I_valid) begin
          w_accept = 1'b1;
          if (r_idx == C_ISWIDTH'(C_INUM - 1)) begin
            w_state_nxt = ST_HOLD;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + C_ISWIDTH'(1);
          end
        end
      end
      ST_HOLD: begin
        if (I_ack && I_start) begin
          w_state_nxt = ST_FILL;
          w_idx_nxt   = '0;
          w_clear     = 1'b1;
        end else if (I_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
    w_ovf_nxt = src.I_valid && !w_accept;
  end

  for (genvar k = 0; k < C_INUM; k++) begin : g_slot
    logic w_we;
    assign w_we = w_accept && (r_idx == C_ISWIDTH'(k));

    always_ff @(posedge I_clk) begin
      if (!I_rst_n || w_clear) begin
        r_slot[k] <= '0;
      end else if (w_we) begin
        r_slot[k] <= src.I_data;
      end
    end

    assign O_data[k*C_IDWIDTH +: C_IDWIDTH] = r_slot[k];
  end

  assign src.O_ready = (r_state == ST_FILL);
  assign O_busy      = (r_state == ST_FILL);
  assign O_done      = (r_state == ST_HOLD);
  assign O_idx       = r_idx;
  assign O_ovf       = r_ovf;

endmodule

// File: tb/tb_meas_demux.sv
module tb_meas_demux;
  localparam int unsigned NUM = 48;
  localparam int unsigned DW  = 24;
  localparam int unsigned SW  = 10;

  typedef logic [NUM*DW-1:0] bus_t;
  typedef struct {
    logic          ready;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [SW-1:0] idx;
    bus_t          data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  bus_t          o_data;
  logic [SW-1:0] o_idx;
  logic          o_busy, o_done, o_ovf;

  meas_demux_if #(.C_IDWIDTH(DW)) u_if ();

  meas_demux #(.C_INUM(NUM), .C_IDWIDTH(DW), .C_ISWIDTH(SW)) u_dut (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .I_start(start),
    .src    (u_if.slave),
    .I_ack  (ack),
    .O_data (o_data),
    .O_idx  (o_idx),
    .O_busy (o_busy),
    .O_done (o_done),
    .O_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  exp_t exp_q[$];
  bus_t frame_q[$];

  // Reference model: a frame is just the list of words received so far.
  int         mode = 0;            // 0 idle, 1 filling, 2 holding
  logic [DW-1:0] got[$];
  logic       m_ovf = 1'b0;

  function automatic bus_t pack_words();
    bus_t b;
    b = '0;
    for (int i = 0; i < got.size(); i++) b[i*DW +: DW] = got[i];
    return b;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
  endtask

  task automatic chk_bus(input string name, input bus_t act, input bus_t want);
    n_chk++;
    if (act == want) n_pass++;
    else begin
      for (int k = 0; k < NUM; k++) begin
        if (act[k*DW +: DW] !== want[k*DW +: DW]) begin
          $display("FAIL %s: slot %0d got 0x%0h expected 0x%0h at %0t",
                   name, k, act[k*DW +: DW], want[k*DW +: DW], $time);
          break;
        end
      end
    end
  endtask

  // Drive one cycle of inputs and predict outputs after the coming edge.
  task automatic cyc(input logic r, input logic s, input logic v,
                     input logic [DW-1:0] d, input logic a);
    exp_t e;
    @(negedge clk);
    rst_n = r; start = s; u_if.I_valid = v; u_if.I_data = d; ack = a;
    if (!r) begin
      mode = 0; got.delete(); m_ovf = 1'b0;
    end else begin
      m_ovf = v;
      case (mode)
        0: if (s) begin mode = 1; got.delete(); end
        1: begin
          if (s) got.delete();
          else if (v) begin
            got.push_back(d);
            m_ovf = 1'b0;
            if (got.size() == NUM) begin
              mode = 2;
              frame_q.push_back(pack_words());
            end
          end
        end
        default: begin
          if (a && s) begin mode = 1; got.delete(); end
          else if (a) mode = 0;
        end
      endcase
    end
    e.ready = (mode == 1);
    e.busy  = (mode == 1);
    e.done  = (mode == 2);
    e.ovf   = m_ovf;
    e.idx   = (mode == 1) ? SW'(got.size()) : '0;
    e.data  = pack_words();
    exp_q.push_back(e);
  endtask

  // Per-cycle monitor.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready", u_if.O_ready, e.ready);
      chk("busy",  o_busy, e.busy);
      chk("done",  o_done, e.done);
      chk("ovf",   o_ovf,  e.ovf);
      chk("idx",   o_idx,  e.idx);
      chk_bus("data", o_data, e.data);
    end
  end

  // Frame monitor: every rising O_done must deliver the next completed frame.
  logic prev_done = 1'b0;
  always @(posedge clk) begin
    #2;
    if (o_done && !prev_done) begin
      if (frame_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        bus_t f;
        f = frame_q.pop_front();
        chk_bus("frame", o_data, f);
        chk("mux_sel5", o_data[5*DW +: DW], f[5*DW +: DW]);
      end
    end
    prev_done = o_done;
  end

  initial begin
    int unsigned first;
    u_if.I_valid = 1'b0;
    u_if.I_data  = '0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 24'h123456, 1);

    // Full frame with valid held high: words 1..48.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < NUM; i++) cyc(1, 0, 1, DW'(i + 1), 0);
    @(negedge clk);
    chk("slot5_direct", o_data[5*DW +: DW], 24'h000006);

    // Overflow in HOLD, then ack.
    cyc(1, 0, 1, 24'hABCDEF, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);             // start without ack ignored
    cyc(1, 0, 0, 0, 1);

    // Toggling valid.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 2 * NUM; i++) cyc(1, 0, (i % 2) == 0, DW'($urandom), 0);

    // Back-to-back ack+start, then restart after 10 accepts.
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, DW'($urandom), 0);
    cyc(1, 1, 1, 24'h777777, 0);
    for (int i = 0; i < NUM; i++) cyc(1, 0, 1, DW'($urandom), 0);
    cyc(1, 0, 0, 0, 0);

    // Reset mid-frame at idx 20.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, DW'($urandom), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 24'h111111, 0);
    cyc(1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          DW'($urandom),
          ($urandom_range(0, 7) == 0));
    end

    cyc(1, 0, 0, 0, 0);
    first = 0;
    while (exp_q.size() > 0 && first < 10) begin
      @(negedge clk);
      first++;
    end
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("frames_drained", frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/meas_demux.md
Name: meas_demux

Overview:
- Write-side counterpart of the measurement mux: gathers a serial stream of C_IDWIDTH-bit measurement words into a bank of C_INUM slots.
- Presents the bank as one flat bus, with slot k at bits [k*C_IDWIDTH +: C_IDWIDTH], so the mux with select k returns the k-th received word.
- Sits between the measurement datapath (word source, valid/ready) and the mux/readout logic (frame consumer, done/ack).

Parameters:
- C_INUM, 48, number of slots per frame.
- C_IDWIDTH, 24, width of one measurement word.
- C_ISWIDTH, 10, slot index width; must satisfy 2**C_ISWIDTH >= C_INUM.

Ports:
- I_clk  input  1  clock; all logic on its rising edge.
- I_rst_n  input  1  reset; synchronous, active-low.
- I_start  input  1  begin a new frame (single-cycle pulse).
- I_valid  input  1  word-source valid.
- I_data  input  C_IDWIDTH  incoming measurement word.
- O_ready  output  1  block accepts a word this cycle.
- I_ack  input  1  consumer has read the completed frame.
- O_data  output  C_INUM*C_IDWIDTH  flat slot bank; registered.
- O_idx  output  C_ISWIDTH  next slot to be written.
- O_busy  output  1  high while a frame is being filled.
- O_done  output  1  frame complete; O_data stable.
- O_ovf  output  1  one-cycle pulse: word offered while not accepting.

Behaviour:
- Interface: one clock I_clk; synchronous active-low reset I_rst_n. Reset is sampled only on a rising edge and overrides all other inputs.
- Reset values: state=IDLE, O_data=0, O_idx=0, O_ready=0, O_busy=0, O_done=0, O_ovf=0.
- States: IDLE, FILL, HOLD. O_ready=O_busy=(state==FILL). O_done=(state==HOLD). All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- IDLE:
  - I_start -> FILL, idx=0, every slot cleared to 0.
  - I_valid -> O_ovf=1 next cycle, word dropped.
- FILL:
  - Accept when I_valid & O_ready: slot[idx] <= I_data. The word is visible on O_data the cycle after acceptance.
  - idx==C_INUM-1 on accept -> HOLD, idx=0.
  - Otherwise idx <= idx+1.
  - I_start in FILL restarts the frame: idx=0, bank cleared. Any word offered in that same cycle is dropped and O_ovf=1. Start has priority over accept.
- HOLD:
  - O_data frozen.
  - I_ack -> IDLE.
  - I_ack & I_start in the same cycle -> FILL directly: idx=0, bank cleared (back-to-back frames).
  - I_start without I_ack is ignored.
  - I_valid -> O_ovf=1, word dropped.
- Latency: first accept to O_done is exactly C_INUM cycles when I_valid is held high. O_done rises the cycle after the last accept.
- Index arithmetic: idx never exceeds C_INUM-1; no wrap through unused codes when C_INUM < 2**C_ISWIDTH.
- O_ovf is not sticky; it is a pulse of one cycle per dropped word.
- Reset mid-frame: returns to IDLE, bank cleared, partial frame discarded, no O_done.
- I_ack outside HOLD is ignored.

Decomposition:
- Package meas_pkg:
  - state encoding (IDLE=2'd0, FILL=2'd1, HOLD=2'd2);
  - clog2 constant function;
  - elaboration check C_INUM <= 2**C_ISWIDTH.
- A sub-module is not required. The slot bank is a generate loop of per-slot write-enable registers decoded from idx.
- If reused elsewhere, factor the bank as meas_slot_bank (write-enable, index, data in; flat bus out).

Test Plan:
- Reset then I_start, then stream 48 words 0x000001..0x000030 with I_valid high -> O_done at cycle 48 after the first accept; slot k = k+1; mux select 5 reads 0x000006.
- I_valid toggling 1/0 during fill -> only valid cycles advance O_idx; O_done after 48 accepts (96 cycles); data order preserved.
- In HOLD, assert I_valid with 0xABCDEF -> O_ovf pulses 1 cycle; O_data unchanged; O_idx=0.
- After 10 accepts, pulse I_start together with I_valid -> word dropped, O_ovf=1, bank all-zero, O_idx=0; the next 48 words fill a fresh frame.
- In HOLD, I_ack & I_start in the same cycle -> next cycle FILL with O_ready=1, O_done=0, bank cleared; I_start alone in HOLD -> no change.
- I_rst_n=0 for one cycle at O_idx=20 -> next cycle all outputs zero, state IDLE; I_valid then yields O_ovf only.
